// File: rtl/axis_nibble_pkg.sv
// Shared constants and state type for the nibble-stream source, buffer and sink.
package axis_nibble_pkg;

    localparam int unsigned AXN_DATA_W    = 4;
    localparam int unsigned AXN_NUM_BEATS = 4;
    localparam int unsigned AXN_CNT_W     = 8;

    typedef enum logic {
        IDLE_S = 1'b0,
        SEND_S = 1'b1
    } axn_state_e;

endpackage

// File: rtl/axis_nibble_tx.sv
// AXI-stream nibble source: serialises a latched packet word LSB beat first,
// honouring backpressure, with a wrapping completed-packet counter.
module axis_nibble_tx
    import axis_nibble_pkg::*;
#(
    parameter int unsigned DATA_W    = AXN_DATA_W,
    parameter int unsigned NUM_BEATS = AXN_NUM_BEATS,
    parameter int unsigned LEN_W     = $clog2(NUM_BEATS),
    parameter int unsigned CNT_W     = AXN_CNT_W
) (
    input  logic                        clk_i,
    input  logic                        arst_i,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic [DATA_W*NUM_BEATS-1:0] cmd_data_i,
    input  logic [LEN_W-1:0]            cmd_len_i,
    output logic                        tvalid_o,
    input  logic                        tready_i,
    output logic [DATA_W-1:0]           tdata_o,
    output logic                        tlast_o,
    output logic                        busy_o,
    output logic [CNT_W-1:0]            pkt_cnt_o
);

    axn_state_e                 state_q, state_d;
    logic [DATA_W*NUM_BEATS-1:0] shreg_q, shreg_d;
    logic [LEN_W-1:0]           beat_rem_q, beat_rem_d;
    logic                       tlast_q, tlast_d;
    logic [CNT_W-1:0]           pkt_cnt_q, pkt_cnt_d;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        beat_rem_d = beat_rem_q;
        tlast_d    = tlast_q;
        pkt_cnt_d  = pkt_cnt_q;
        case (state_q)
            IDLE_S: begin
                if (cmd_valid_i) begin
                    shreg_d    = cmd_data_i;
                    beat_rem_d = cmd_len_i;
                    tlast_d    = (cmd_len_i == '0);
                    state_d    = SEND_S;
                end
            end
            SEND_S: begin
                if (tready_i) begin
                    if (tlast_q) begin
                        state_d   = IDLE_S;
                        tlast_d   = 1'b0;
                        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                    end else begin
                        // beat_rem counts beats still to come after the current one
                        shreg_d    = shreg_q >> DATA_W;
                        beat_rem_d = beat_rem_q - LEN_W'(1);
                        tlast_d    = (beat_rem_q == LEN_W'(1));
                    end
                end
            end
            default: begin
                state_d = IDLE_S;
                tlast_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= IDLE_S;
            shreg_q    <= '0;
            beat_rem_q <= '0;
            tlast_q    <= 1'b0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            beat_rem_q <= beat_rem_d;
            tlast_q    <= tlast_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    // Handshake outputs decode straight from state so reset drops them at once.
    assign cmd_ready_o = (state_q == IDLE_S);
    assign busy_o      = (state_q == SEND_S);
    assign tvalid_o    = (state_q == SEND_S);
    assign tlast_o     = tlast_q;
    assign tdata_o     = shreg_q[DATA_W-1:0];
    assign pkt_cnt_o   = pkt_cnt_q;

endmodule

// File: tb/tb_axis_nibble_tx.sv
// Randomised self-checking bench for axis_nibble_tx against a packet-level model.
module tb_axis_nibble_tx;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_data = '0;
    logic [1:0]  cmd_len = '0;
    logic        tvalid;
    logic        tready = 1'b0;
    logic [3:0]  tdata;
    logic        tlast;
    logic        busy;
    logic [7:0]  pkt_cnt;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    axis_nibble_tx #(
        .DATA_W    (4),
        .NUM_BEATS (4),
        .LEN_W     (2),
        .CNT_W     (8)
    ) dut (
        .clk_i       (clk),
        .arst_i      (arst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_data_i  (cmd_data),
        .cmd_len_i   (cmd_len),
        .tvalid_o    (tvalid),
        .tready_i    (tready),
        .tdata_o     (tdata),
        .tlast_o     (tlast),
        .busy_o      (busy),
        .pkt_cnt_o   (pkt_cnt)
    );

    // Starts and ends on a falling edge. Issues one command and consumes the packet,
    // checking every cycle against the beats the model says the word should produce.
    task automatic run_packet(input logic [15:0] data, input logic [1:0] len,
                              input bit rand_bp, input int stall_beat,
                              input int stall_len, input bit keep_valid);
        int k = 0;
        int guard = 0;
        int stalled = 0;
        int first_seen = -1;
        logic [3:0] exp_nib;
        bit r;
        total++;
        if (cmd_ready !== 1'b1 || tvalid !== 1'b0) begin
            bad++;
            $display("FAIL pre_cmd: ready=%b tvalid=%b required ready=1 tvalid=0", cmd_ready, tvalid);
        end
        cmd_valid = 1'b1;
        cmd_data  = data;
        cmd_len   = len;
        @(negedge clk);
        cmd_valid = keep_valid;
        cmd_data  = 16'($urandom);
        cmd_len   = 2'($urandom);
        while (k <= int'(len) && guard < 200) begin
            exp_nib = 4'((data >> (4 * k)) & 16'hF);
            total++;
            if (tvalid !== 1'b1 || tdata !== exp_nib || tlast !== (k == int'(len))
                || cmd_ready !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL beat%0d: tvalid=%b tdata=%h tlast=%b ready=%b busy=%b required 1 %h %b 0 1",
                         k, tvalid, tdata, tlast, cmd_ready, busy, exp_nib, (k == int'(len)));
            end
            if (k == stall_beat && stalled < stall_len) begin
                r = 1'b0;
                stalled++;
            end else begin
                r = rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            tready = r;
            if (first_seen < 0) first_seen = guard;
            @(negedge clk);
            guard++;
            if (r) k++;
        end
        if (guard >= 200) begin
            total++;
            bad++;
            $display("FAIL timeout: beats_done=%0d required %0d", k, int'(len) + 1);
        end
        tready = 1'b0;
        exp_cnt = (exp_cnt + 1) % 256;
        total++;
        if (tvalid !== 1'b0 || tlast !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0
            || pkt_cnt !== 8'(exp_cnt)) begin
            bad++;
            $display("FAIL post_pkt: tvalid=%b tlast=%b ready=%b busy=%b cnt=%0d required 0 0 1 0 %0d",
                     tvalid, tlast, cmd_ready, busy, pkt_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== 4'h0 || busy !== 1'b0 || pkt_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset: tvalid=%b tlast=%b tdata=%h busy=%b cnt=%0d required 0 0 0 0 0",
                     tvalid, tlast, tdata, busy, pkt_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1 || tvalid !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: ready=%b tvalid=%b required 1 0", cmd_ready, tvalid);
        end
        exp_cnt = 0;
    endtask

    task automatic test_full_packet();
        run_packet(16'hA5C3, 2'd3, 1'b0, -1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_packet(16'hA5C3, 2'd3, 1'b0, 2, 3, 1'b0);
        for (int i = 0; i < 6; i++)
            run_packet(16'($urandom), 2'($urandom), 1'b1, int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 5)), 1'b0);
    endtask

    task automatic test_short_packets();
        run_packet(16'h000F, 2'd0, 1'b0, -1, 0, 1'b0);
        run_packet(16'h1234, 2'd1, 1'b0, -1, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_packet(16'hBEEF, 2'd3, 1'b0, -1, 0, 1'b1);
        run_packet(16'h7316, 2'd2, 1'b1, -1, 0, 1'b0);
    endtask

    task automatic test_reset_mid_packet();
        cmd_valid = 1'b1;
        cmd_data  = 16'hDCBA;
        cmd_len   = 2'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        tready    = 1'b1;
        @(negedge clk);
        total++;
        if (tvalid !== 1'b1 || tdata !== 4'hB) begin
            bad++;
            $display("FAIL mid_beat1: tvalid=%b tdata=%h required 1 b", tvalid, tdata);
        end
        #2 arst = 1'b1;
        #1;
        total++;
        if (tvalid !== 1'b0 || tlast !== 1'b0 || busy !== 1'b0 || pkt_cnt !== 8'd0) begin
            bad++;
            $display("FAIL mid_reset: tvalid=%b tlast=%b busy=%b cnt=%0d required 0 0 0 0",
                     tvalid, tlast, busy, pkt_cnt);
        end
        tready = 1'b0;
        @(negedge clk);
        arst = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        run_packet(16'h8421, 2'd3, 1'b0, -1, 0, 1'b0);
    endtask

    task automatic test_counter_wrap();
        for (int i = 0; i < 257; i++)
            run_packet(16'($urandom), 2'd0, 1'b0, -1, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_full_packet();
        test_backpressure();
        test_short_packets();
        test_back_to_back();
        test_reset_mid_packet();
        test_counter_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
